// File: rtl/sys_tick_sequencer_if.sv
// sys_tick_sequencer_if: Avalon-MM link between the tick sequencer (master)
// and the 16-bit interval timer (slave). 3-bit word address, 16-bit data,
// registered readdata, no waitrequest, level interrupt from the timer.

interface sys_tick_sequencer_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/sys_tick_sequencer.sv
// sys_tick_sequencer: sole Avalon-MM master of the interval timer. Starts and
// stops the timer with i_run, clears its timeout on every IRQ and fans each
// serviced base tick out to NUM_CH channels with their own divisor, sticky
// pending flag and sticky overrun flag.
// Optional macro SYS_TICK_SNAP_EN: on every IRQ the timer counter is also
// snapshotted and read back into o_snap_value before the dispatch cycle.

module sys_tick_sequencer #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_run,
    sys_tick_sequencer_if.master    tmr,
    input  logic [NUM_CH-1:0]       i_ch_en,
    input  logic [NUM_CH*DIV_W-1:0] i_ch_div,
    input  logic [NUM_CH-1:0]       i_ch_ack,
    output logic [NUM_CH-1:0]       o_ch_tick,
    output logic [NUM_CH-1:0]       o_ch_pending,
    output logic [NUM_CH-1:0]       o_ch_overrun,
    output logic [31:0]             o_tick_count,
    output logic                    o_busy
`ifdef SYS_TICK_SNAP_EN
    ,
    output logic [15:0]             o_snap_value
`endif
);

    // Timer register map and the command words the sequencer issues.
    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_SNAPL   = 3'd4;
    localparam logic [15:0] CTRL_START   = 16'h0007;
    localparam logic [15:0] CTRL_STOP    = 16'h0008;
    localparam logic [15:0] DATA_ZERO    = 16'h0000;

    typedef enum logic [3:0] {
        S_HALT,
        S_START,
        S_IDLE,
        S_STOP,
        S_CLR,
        S_DISP
`ifdef SYS_TICK_SNAP_EN
        ,
        S_SNAPW,
        S_SNAPR,
        S_SNAPD
`endif
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [2:0]  w_busAddr;
    logic        w_busCs;
    logic        w_busWrN;
    logic [15:0] w_busData;
    logic [2:0]  r_busAddr;
    logic        r_busCs;
    logic        r_busWrN;
    logic [15:0] r_busData;

    logic                w_dispatch;
    logic [DIV_W-1:0]    r_cnt     [NUM_CH];
    logic [DIV_W-1:0]    w_cntNext [NUM_CH];
    logic [DIV_W-1:0]    w_reload  [NUM_CH];
    logic [NUM_CH-1:0]   w_event;
    logic [NUM_CH-1:0]   r_tick;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_overrun;
    logic [31:0]         r_tickCount;

    // State register; reset parks the sequencer halted and leaves the timer alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode, then the bus command owned by the state being entered,
    // so the registered bus lines show each access exactly during its state.
    always_comb begin
        w_nextState = r_state;
        w_busCs     = 1'b0;
        w_busWrN    = 1'b1;
        w_busAddr   = 3'd0;
        w_busData   = DATA_ZERO;

        case (r_state)
            S_HALT: begin
                if (i_run) begin
                    w_nextState = S_START;
                end
            end
            S_START: begin
                w_nextState = S_IDLE;
            end
            S_IDLE: begin
                if (!i_run) begin
                    w_nextState = S_STOP;
                end else if (tmr.irq) begin
                    w_nextState = S_CLR;
                end
            end
            S_STOP: begin
                w_nextState = S_HALT;
            end
            S_CLR: begin
`ifdef SYS_TICK_SNAP_EN
                w_nextState = S_SNAPW;
`else
                w_nextState = S_DISP;
`endif
            end
`ifdef SYS_TICK_SNAP_EN
            S_SNAPW: begin
                w_nextState = S_SNAPR;
            end
            S_SNAPR: begin
                w_nextState = S_SNAPD;
            end
            S_SNAPD: begin
                w_nextState = S_DISP;
            end
`endif
            S_DISP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_HALT;
            end
        endcase

        case (w_nextState)
            S_START: begin
                w_busCs   = 1'b1;
                w_busWrN  = 1'b0;
                w_busAddr = ADDR_CONTROL;
                w_busData = CTRL_START;
            end
            S_STOP: begin
                w_busCs   = 1'b1;
                w_busWrN  = 1'b0;
                w_busAddr = ADDR_CONTROL;
                w_busData = CTRL_STOP;
            end
            S_CLR: begin
                w_busCs   = 1'b1;
                w_busWrN  = 1'b0;
                w_busAddr = ADDR_STATUS;
                w_busData = DATA_ZERO;
            end
`ifdef SYS_TICK_SNAP_EN
            S_SNAPW: begin
                w_busCs   = 1'b1;
                w_busWrN  = 1'b0;
                w_busAddr = ADDR_SNAPL;
                w_busData = DATA_ZERO;
            end
            S_SNAPR: begin
                w_busCs   = 1'b1;
                w_busWrN  = 1'b1;
                w_busAddr = ADDR_SNAPL;
            end
`endif
            default: begin
            end
        endcase
    end

    // Registered bus outputs; async reset drops any access in flight at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busCs   <= 1'b0;
            r_busWrN  <= 1'b1;
            r_busAddr <= 3'd0;
            r_busData <= DATA_ZERO;
        end else begin
            r_busCs   <= w_busCs;
            r_busWrN  <= w_busWrN;
            r_busAddr <= w_busAddr;
            r_busData <= w_busData;
        end
    end

    assign tmr.chipselect = r_busCs;
    assign tmr.write_n    = r_busWrN;
    assign tmr.address    = r_busAddr;
    assign tmr.writedata  = r_busData;

    assign w_dispatch = (r_state == S_DISP);

    // Per-channel divider step: a divisor of 0 behaves as 1, disabled channels
    // sit preloaded, and a new divisor only lands at the next reload.
    always_comb begin
        w_event = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_ch_div[i*DIV_W +: DIV_W] == '0) begin
                w_reload[i] = '0;
            end else begin
                w_reload[i] = i_ch_div[i*DIV_W +: DIV_W] - DIV_W'(1);
            end
            w_cntNext[i] = r_cnt[i];
            if (w_dispatch) begin
                if (!i_ch_en[i]) begin
                    w_cntNext[i] = w_reload[i];
                end else if (r_cnt[i] == '0) begin
                    w_event[i]   = 1'b1;
                    w_cntNext[i] = w_reload[i];
                end else begin
                    w_cntNext[i] = r_cnt[i] - DIV_W'(1);
                end
            end
        end
    end

    // Channel down-counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    // Event flags: a new event beats a same-edge ack, and an event landing on an
    // already pending channel marks it overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick    <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_tick    <= w_event;
            r_pending <= w_event | (r_pending & ~i_ch_ack);
            r_overrun <= (w_event & r_pending) | (r_overrun & ~i_ch_ack);
        end
    end

    // Count of serviced base ticks, wrapping naturally at 32 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tickCount <= 32'd0;
        end else if (w_dispatch) begin
            r_tickCount <= r_tickCount + 32'd1;
        end
    end

`ifdef SYS_TICK_SNAP_EN
    logic [15:0] r_snapValue;

    // Capture the snapshot register; its readdata is valid in S_SNAPD, one
    // cycle after the read address went out in S_SNAPR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snapValue <= 16'h0000;
        end else if (r_state == S_SNAPD) begin
            r_snapValue <= tmr.readdata;
        end
    end

    assign o_snap_value = r_snapValue;
`else
    logic w_unusedReaddata;
    assign w_unusedReaddata = ^tmr.readdata;
`endif

    assign o_ch_tick    = r_tick;
    assign o_ch_pending = r_pending;
    assign o_ch_overrun = r_overrun;
    assign o_tick_count = r_tickCount;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule

// File: tb/tb_sys_tick_sequencer.sv
// tb_sys_tick_sequencer: drives sys_tick_sequencer against a small behavioural
// model of the interval timer; dispatch vectors come from a table, the
// start/stop, ack and reset corner cases are hand-written sequences.

module tb_sys_tick_sequencer;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
`ifdef SYS_TICK_SNAP_EN
    localparam int BUSY_CYC = 5;
`else
    localparam int BUSY_CYC = 2;
`endif
    localparam logic [63:0] DIV_A = 64'h0000_0000_0003_0001;
    localparam logic [63:0] DIV_B = 64'h0000_0000_0002_0001;

    typedef struct {
        logic [3:0]  en;
        logic [63:0] div;
        logic [3:0]  ack;
        logic [3:0]  expTick;
        logic [3:0]  expPend;
        logic [3:0]  expOvr;
        logic [31:0] expCount;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  chEn = 4'b0000;
    logic [63:0] chDiv = 64'd0;
    logic [3:0]  chAck = 4'b0000;
    logic [3:0]  chTick;
    logic [3:0]  chPending;
    logic [3:0]  chOverrun;
    logic [31:0] tickCount;
    logic        busy;
`ifdef SYS_TICK_SNAP_EN
    logic [15:0] snapValue;
`endif

    int nChecks = 0;
    int nFails  = 0;

    sys_tick_sequencer_if tmrBus ();

    sys_tick_sequencer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_run        (run),
        .tmr          (tmrBus),
        .i_ch_en      (chEn),
        .i_ch_div     (chDiv),
        .i_ch_ack     (chAck),
        .o_ch_tick    (chTick),
        .o_ch_pending (chPending),
        .o_ch_overrun (chOverrun),
        .o_tick_count (tickCount),
        .o_busy       (busy)
`ifdef SYS_TICK_SNAP_EN
        ,
        .o_snap_value (snapValue)
`endif
    );

    always #5 clk = ~clk;

    // Interval timer model: status at 0 (TO, RUN), control at 1 (ITO, CONT,
    // START, STOP), snapshot at 4; registered readdata and registered irq.
    int          tmrPeriod = 100;
    int          tmrCnt;
    logic        tmrRunning;
    logic        tmrTo;
    logic        tmrIto;
    logic        tmrCont;
    logic        tmrIrqReg;
    logic        forceIrq = 1'b0;
    logic [15:0] tmrSnap;
    logic [15:0] tmrRead;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmrCnt     <= 0;
            tmrRunning <= 1'b0;
            tmrTo      <= 1'b0;
            tmrIto     <= 1'b0;
            tmrCont    <= 1'b0;
            tmrIrqReg  <= 1'b0;
            tmrSnap    <= 16'h0000;
            tmrRead    <= 16'h0000;
        end else begin
            tmrIrqReg <= tmrTo & tmrIto;
            case (tmrBus.address)
                3'd0:    tmrRead <= {14'd0, tmrRunning, tmrTo};
                3'd4:    tmrRead <= tmrSnap;
                default: tmrRead <= 16'h0000;
            endcase
            if (tmrBus.chipselect && !tmrBus.write_n) begin
                case (tmrBus.address)
                    3'd0: tmrTo <= 1'b0;
                    3'd1: begin
                        tmrIto  <= tmrBus.writedata[0];
                        tmrCont <= tmrBus.writedata[1];
                        if (tmrBus.writedata[2]) begin
                            tmrRunning <= 1'b1;
                            tmrCnt     <= tmrPeriod - 1;
                        end
                        if (tmrBus.writedata[3]) begin
                            tmrRunning <= 1'b0;
                        end
                    end
                    3'd4: tmrSnap <= tmrCnt[15:0];
                    default: begin
                    end
                endcase
            end
            if (tmrRunning) begin
                if (tmrCnt == 0) begin
                    tmrTo  <= 1'b1;
                    tmrCnt <= tmrPeriod - 1;
                    if (!tmrCont) begin
                        tmrRunning <= 1'b0;
                    end
                end else begin
                    tmrCnt <= tmrCnt - 1;
                end
            end
        end
    end

    assign tmrBus.readdata = tmrRead;
    assign tmrBus.irq      = tmrIrqReg | forceIrq;

    // Bus, tick-pulse and busy-length monitor, sampled mid-cycle.
    int nStartWr = 0;
    int nStopWr  = 0;
    int nClrWr   = 0;
    int pulse0   = 0;
    int pulse1   = 0;
    int busyRun  = 0;
    int lastBusyRun = 0;

    always @(negedge clk) begin
        if (tmrBus.chipselect && !tmrBus.write_n) begin
            if (tmrBus.address == 3'd1 && tmrBus.writedata == 16'h0007) nStartWr++;
            if (tmrBus.address == 3'd1 && tmrBus.writedata == 16'h0008) nStopWr++;
            if (tmrBus.address == 3'd0 && tmrBus.writedata == 16'h0000) nClrWr++;
        end
        if (chTick[0]) pulse0++;
        if (chTick[1]) pulse1++;
        if (busy) begin
            busyRun++;
        end else begin
            if (busyRun != 0) lastBusyRun = busyRun;
            busyRun = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failTimeout(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: actual timeout, required event within bound", name);
    endtask

    // Waits for tick_count to move, i.e. the negedge just after a dispatch.
    task automatic waitDispatch(input string name);
        logic [31:0] prev;
        bit seen;
        prev = tickCount;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tickCount != prev) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failTimeout(name);
    endtask

    task automatic waitBusy(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failTimeout(name);
    endtask

    task automatic applyStimulus(input vec_t v);
        chEn  = v.en;
        chDiv = v.div;
        if (v.ack != 4'b0000) begin
            chAck = v.ack;
            @(negedge clk);
            chAck = 4'b0000;
        end
    endtask

    function automatic vec_t mkVec(input logic [3:0] en, input logic [63:0] div,
                                   input logic [3:0] ack, input logic [3:0] tick,
                                   input logic [3:0] pend, input logic [3:0] ovr,
                                   input int cnt);
        vec_t v;
        v.en       = en;
        v.div      = div;
        v.ack      = ack;
        v.expTick  = tick;
        v.expPend  = pend;
        v.expOvr   = ovr;
        v.expCount = 32'(cnt);
        return v;
    endfunction

    initial begin
        vec_t vecs [18];
        int   waited;
        int   clrBefore;
        int   expCount;

        // Ch0 div1, ch1 div3: ch1 fires on dispatches 1,4,7,10.
        vecs[0]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 1);
        vecs[1]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0001, 4'b0011, 4'b0001, 2);
        vecs[2]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0001, 4'b0011, 4'b0001, 3);
        vecs[3]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 4);
        vecs[4]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0001, 4'b0011, 4'b0011, 5);
        vecs[5]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0001, 4'b0011, 4'b0011, 6);
        vecs[6]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 7);
        vecs[7]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0001, 4'b0011, 4'b0011, 8);
        vecs[8]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0001, 4'b0011, 4'b0011, 9);
        vecs[9]  = mkVec(4'b0011, DIV_A, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 10);
        // Ch2 with divisor 0 fires every dispatch; ch0/ch1 acked and disabled.
        vecs[10] = mkVec(4'b0100, DIV_A, 4'b0011, 4'b0100, 4'b0100, 4'b0000, 11);
        vecs[11] = mkVec(4'b0100, DIV_A, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 12);
        vecs[12] = mkVec(4'b0100, DIV_A, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 13);
        // Ch1 re-enabled preloaded with 2 (old div 3); new div 2 applies after.
        vecs[13] = mkVec(4'b0010, DIV_B, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 14);
        vecs[14] = mkVec(4'b0010, DIV_B, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 15);
        vecs[15] = mkVec(4'b0010, DIV_B, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 16);
        vecs[16] = mkVec(4'b0010, DIV_B, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 17);
        vecs[17] = mkVec(4'b0010, DIV_B, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 18);

        // Reset state.
        @(negedge clk);
        checkOutput("rstChipselect", 64'(tmrBus.chipselect), 64'd0);
        checkOutput("rstWriteN", 64'(tmrBus.write_n), 64'd1);
        checkOutput("rstAddress", 64'(tmrBus.address), 64'd0);
        checkOutput("rstWritedata", 64'(tmrBus.writedata), 64'd0);
        checkOutput("rstTickCount", 64'(tickCount), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstFlags", {52'd0, chTick, chPending, chOverrun}, 64'd0);
        reset_n = 1'b1;

        // Start: one control write the cycle after HALT sees run.
        repeat (2) @(negedge clk);
        run = 1'b1;
        waited = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tmrBus.chipselect) begin
                waited = i;
                break;
            end
        end
        checkOutput("startLatency", 64'(waited), 64'd0);
        checkOutput("startWrN", 64'(tmrBus.write_n), 64'd0);
        checkOutput("startAddr", 64'(tmrBus.address), 64'd1);
        checkOutput("startData", 64'(tmrBus.writedata), 64'h7);
        @(negedge clk);
        checkOutput("idleChipselect", 64'(tmrBus.chipselect), 64'd0);
        checkOutput("idleBusy", 64'(busy), 64'd0);
        checkOutput("idleTickCount", 64'(tickCount), 64'd0);

        // Table-driven dispatches.
        for (int v = 0; v < 18; v++) begin
            applyStimulus(vecs[v]);
            waitDispatch($sformatf("dispatch%0d", v + 1));
            checkOutput($sformatf("tick%0d", v + 1), 64'(chTick), 64'(vecs[v].expTick));
            checkOutput($sformatf("pend%0d", v + 1), 64'(chPending), 64'(vecs[v].expPend));
            checkOutput($sformatf("ovr%0d", v + 1), 64'(chOverrun), 64'(vecs[v].expOvr));
            checkOutput($sformatf("count%0d", v + 1), 64'(tickCount), 64'(vecs[v].expCount));
`ifdef SYS_TICK_SNAP_EN
            checkOutput($sformatf("snap%0d", v + 1), 64'(snapValue), 64'(tmrSnap));
`endif
            if (v == 9) begin
                #1;
                checkOutput("clrWrites10", 64'(nClrWr), 64'd10);
                checkOutput("pulses0", 64'(pulse0), 64'd10);
                checkOutput("pulses1", 64'(pulse1), 64'd4);
                checkOutput("startWrites", 64'(nStartWr), 64'd1);
                checkOutput("stopWrites0", 64'(nStopWr), 64'd0);
                checkOutput("busyCycles", 64'(lastBusyRun), 64'(BUSY_CYC));
            end
        end
        expCount = 18;

        // Overrun build-up, ack racing an event, then a lone ack.
        chEn  = 4'b0001;
        chDiv = DIV_B;
        chAck = 4'b1111;
        @(negedge clk);
        chAck = 4'b0000;
        waitDispatch("ovrDispatchA");
        expCount++;
        checkOutput("ovrPendA", 64'(chPending), 64'h1);
        checkOutput("ovrOvrA", 64'(chOverrun), 64'h0);
        waitDispatch("ovrDispatchB");
        expCount++;
        checkOutput("ovrPendB", 64'(chPending), 64'h1);
        checkOutput("ovrOvrB", 64'(chOverrun), 64'h1);
        waitBusy("ackRaceBusy");
        repeat (BUSY_CYC - 1) @(posedge clk);
        #1 chAck = 4'b0001;
        @(posedge clk);
        #1 chAck = 4'b0000;
        @(negedge clk);
        expCount++;
        checkOutput("ackRaceTick", 64'(chTick), 64'h1);
        checkOutput("ackRacePend", 64'(chPending), 64'h1);
        checkOutput("ackRaceOvr", 64'(chOverrun), 64'h1);
        checkOutput("ackRaceCount", 64'(tickCount), 64'(expCount));
        chAck = 4'b0001;
        @(negedge clk);
        chAck = 4'b0000;
        checkOutput("ackAlonePend", 64'(chPending), 64'h0);
        checkOutput("ackAloneOvr", 64'(chOverrun), 64'h0);

        // run dropped in S_CLR: dispatch completes, then stop, then halted.
        waitBusy("stopBusy");
        run = 1'b0;
        waitDispatch("stopDispatch");
        expCount++;
        checkOutput("stopCount", 64'(tickCount), 64'(expCount));
        checkOutput("stopTick", 64'(chTick), 64'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (nStopWr != 0) break;
        end
        checkOutput("stopWrite", 64'(nStopWr), 64'd1);
        @(negedge clk);
        checkOutput("haltBusy", 64'(busy), 64'd0);
        clrBefore = nClrWr;
        forceIrq  = 1'b1;
        repeat (20) @(negedge clk);
        forceIrq  = 1'b0;
        #1;
        checkOutput("haltCount", 64'(tickCount), 64'(expCount));
        checkOutput("haltClr", 64'(nClrWr), 64'(clrBefore));
        checkOutput("haltPend", 64'(chPending), 64'h1);

        // Restart.
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (nStartWr == 2) break;
        end
        checkOutput("restartWrite", 64'(nStartWr), 64'd2);
        waitDispatch("restartDispatch");
        expCount++;
        checkOutput("restartCount", 64'(tickCount), 64'(expCount));
        checkOutput("restartOvr", 64'(chOverrun), 64'h1);

        // Async reset while the clear write is on the bus.
        waited = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tmrBus.chipselect) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) failTimeout("resetAccess");
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncChipselect", 64'(tmrBus.chipselect), 64'd0);
        checkOutput("asyncWriteN", 64'(tmrBus.write_n), 64'd1);
        checkOutput("asyncAddress", 64'(tmrBus.address), 64'd0);
        checkOutput("asyncBusy", 64'(busy), 64'd0);
        checkOutput("asyncCount", 64'(tickCount), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
